// File: rtl/mcpu_core_itlb_if.sv
// rtl/mcpu_core_itlb_if.sv - fetch translation and PTE read bus for the instruction TLB
// slave is the TLB side; master is the fetch stage / memory side.
interface mcpu_core_itlb_if;
  logic        ft2itlb_valid;
  logic [19:0] ft2itlb_virtpage;
  logic        ft2itlb_ready;
  logic [19:0] ft2itlb_physpage;
  logic        ft2itlb_pagefault;
  logic        itlb2mem_valid;
  logic [29:0] itlb2mem_addr;
  logic        mem2itlb_ready;
  logic        mem2itlb_rvalid;
  logic [31:0] mem2itlb_rdata;

  modport slave (
    input  ft2itlb_valid, ft2itlb_virtpage,
    output ft2itlb_ready, ft2itlb_physpage, ft2itlb_pagefault,
    output itlb2mem_valid, itlb2mem_addr,
    input  mem2itlb_ready, mem2itlb_rvalid, mem2itlb_rdata
  );

  modport master (
    output ft2itlb_valid, ft2itlb_virtpage,
    input  ft2itlb_ready, ft2itlb_physpage, ft2itlb_pagefault,
    input  itlb2mem_valid, itlb2mem_addr,
    output mem2itlb_ready, mem2itlb_rvalid, mem2itlb_rdata
  );
endinterface

// File: rtl/mcpu_core_itlb.sv
// rtl/mcpu_core_itlb.sv - fully associative instruction TLB with two-level page walker
// Hits answer combinationally; misses walk PDE then PTE over a single-outstanding read port.
module mcpu_core_itlb #(
  parameter int ENTRIES = 4
) (
  input  logic                clkrst_core_clk,
  input  logic                clkrst_core_rst_n,
  input  logic [19:0]         paging_ptbr,
  input  logic                itlb_flush,
  mcpu_core_itlb_if.slave     bus
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L2_REQ  = 3'd3,
    L2_WAIT = 3'd4,
    FAULT   = 3'd5
  } state_e;

  state_e             state_q;
  logic [ENTRIES-1:0] ent_valid_q;
  logic [19:0]        ent_tag_q   [ENTRIES];
  logic [19:0]        ent_ppage_q [ENTRIES];
  logic [PW-1:0]      fill_ptr_q;
  logic [19:0]        walk_vpage_q;
  logic               discard_q;
  logic               mem_valid_q;
  logic [29:0]        mem_addr_q;

  logic               hit;
  logic [19:0]        hit_ppage;
  logic               fault_match;
  logic               discard_now;
  logic               pte_present;
  logic               fill_en;
  logic               unused_rdata_bits;

  always_comb begin
    hit       = 1'b0;
    hit_ppage = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_valid_q[i] && (ent_tag_q[i] == bus.ft2itlb_virtpage)) begin
        hit       = 1'b1;
        hit_ppage = ent_ppage_q[i];
      end
    end
  end

  assign fault_match = (state_q == FAULT) && (bus.ft2itlb_virtpage == walk_vpage_q);
  assign discard_now = discard_q | itlb_flush;
  assign pte_present = bus.mem2itlb_rdata[0];
  // A flush landing on the fill cycle wins: the returning PTE is dropped.
  assign fill_en     = (state_q == L2_WAIT) && bus.mem2itlb_rvalid && pte_present && !discard_now;

  assign bus.ft2itlb_ready     = bus.ft2itlb_valid & (hit | fault_match);
  assign bus.ft2itlb_physpage  = hit ? hit_ppage : 20'h0;
  assign bus.ft2itlb_pagefault = bus.ft2itlb_valid & fault_match & ~hit;
  assign bus.itlb2mem_valid    = mem_valid_q;
  assign bus.itlb2mem_addr     = mem_addr_q;
  assign unused_rdata_bits     = ^bus.mem2itlb_rdata[11:1];

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q      <= IDLE;
      ent_valid_q  <= '0;
      fill_ptr_q   <= '0;
      walk_vpage_q <= '0;
      discard_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      if (itlb_flush) begin
        ent_valid_q <= '0;
        fill_ptr_q  <= '0;
      end else if (fill_en) begin
        ent_valid_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q              <= fill_ptr_q + PW'(1);
      end

      case (state_q)
        IDLE: begin
          discard_q <= 1'b0;
          if (bus.ft2itlb_valid && !hit && !itlb_flush) begin
            walk_vpage_q <= bus.ft2itlb_virtpage;
            mem_valid_q  <= 1'b1;
            mem_addr_q   <= {paging_ptbr, bus.ft2itlb_virtpage[19:10]};
            state_q      <= L1_REQ;
          end
        end
        L1_REQ: begin
          if (itlb_flush) discard_q <= 1'b1;
          if (bus.mem2itlb_ready) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            state_q     <= L1_WAIT;
          end
        end
        L1_WAIT: begin
          if (itlb_flush) discard_q <= 1'b1;
          if (bus.mem2itlb_rvalid) begin
            if (discard_now) begin
              state_q <= IDLE;
            end else if (!pte_present) begin
              state_q <= FAULT;
            end else begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= {bus.mem2itlb_rdata[31:12], walk_vpage_q[9:0]};
              state_q     <= L2_REQ;
            end
          end
        end
        L2_REQ: begin
          if (itlb_flush) discard_q <= 1'b1;
          if (bus.mem2itlb_ready) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            state_q     <= L2_WAIT;
          end
        end
        L2_WAIT: begin
          if (itlb_flush) discard_q <= 1'b1;
          if (bus.mem2itlb_rvalid) begin
            state_q <= (!discard_now && !pte_present) ? FAULT : IDLE;
          end
        end
        FAULT: begin
          if (!bus.ft2itlb_valid || (bus.ft2itlb_virtpage != walk_vpage_q) || itlb_flush) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/ppage storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clkrst_core_clk) begin
    if (fill_en) begin
      ent_tag_q[fill_ptr_q]   <= walk_vpage_q;
      ent_ppage_q[fill_ptr_q] <= bus.mem2itlb_rdata[31:12];
    end
  end

endmodule

// File: tb/tb_mcpu_core_itlb.sv
// tb/tb_mcpu_core_itlb.sv - directed self-checking bench for mcpu_core_itlb
// A small PTE memory answers accepted reads after rsp_delay extra cycles.
module tb_mcpu_core_itlb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] ptbr;
  logic        flush;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mem [logic [29:0]];
  int          rsp_delay;
  logic        pend;
  int          pend_cnt;
  logic [29:0] pend_addr;

  always #5 clk = ~clk;

  mcpu_core_itlb_if bus_if();

  mcpu_core_itlb #(.ENTRIES(4)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .paging_ptbr       (ptbr),
    .itlb_flush        (flush),
    .bus               (bus_if)
  );

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk or negedge clk) begin
    if (!rst_n) begin
      pend                    <= 1'b0;
      pend_cnt                <= 0;
      pend_addr               <= '0;
      bus_if.mem2itlb_rvalid  <= 1'b0;
      bus_if.mem2itlb_rdata   <= '0;
    end else if (clk) begin
      if (bus_if.itlb2mem_valid && bus_if.mem2itlb_ready) begin
        pend      <= 1'b1;
        pend_cnt  <= rsp_delay;
        pend_addr <= bus_if.itlb2mem_addr;
      end
    end else begin
      bus_if.mem2itlb_rvalid <= 1'b0;
      bus_if.mem2itlb_rdata  <= '0;
      if (pend) begin
        if (pend_cnt == 0) begin
          bus_if.mem2itlb_rvalid <= 1'b1;
          bus_if.mem2itlb_rdata  <= mem_rd(pend_addr);
          pend                   <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents vp from the current cycle and measures cycles until ready.
  task automatic walk(input string tag, input logic [19:0] vp, input logic [19:0] exp_pp,
                      input logic exp_pf, input int exp_lat);
    int lat;
    lat = -1;
    bus_if.ft2itlb_valid    = 1'b1;
    bus_if.ft2itlb_virtpage = vp;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus_if.ft2itlb_ready === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " physpage"}, {12'h0, bus_if.ft2itlb_physpage}, {12'h0, exp_pp});
    chk({tag, " pagefault"}, {31'h0, bus_if.ft2itlb_pagefault}, {31'h0, exp_pf});
  endtask

  initial begin
    mem[30'h0004002] = 32'h12345001;
    mem[30'h48D16BC] = 32'h7F001001;
    mem[30'h48D1401] = 32'h50001001;
    mem[30'h48D1402] = 32'h50002001;
    mem[30'h48D1403] = 32'h50003001;
    mem[30'h48D1404] = 32'h50004001;
    mem[30'h0004003] = 32'h22222001;
    mem[30'h8888801] = 32'h60001001;
    mem[30'h8888802] = 32'h60002001;
    mem[30'h8888803] = 32'h60003001;
    mem[30'h8888804] = 32'h60004001;

    ptbr                    = 20'h00010;
    flush                   = 1'b0;
    rsp_delay               = 0;
    bus_if.ft2itlb_valid    = 1'b0;
    bus_if.ft2itlb_virtpage = '0;
    bus_if.mem2itlb_ready   = 1'b1;

    // Reset values
    tick(); tick();
    bus_if.ft2itlb_valid    = 1'b1;
    bus_if.ft2itlb_virtpage = 20'h00ABC;
    #1;
    chk("rst mem_valid", {31'h0, bus_if.itlb2mem_valid}, 32'h0);
    chk("rst mem_addr", {2'h0, bus_if.itlb2mem_addr}, 32'h0);
    chk("rst ready", {31'h0, bus_if.ft2itlb_ready}, 32'h0);
    chk("rst pagefault", {31'h0, bus_if.ft2itlb_pagefault}, 32'h0);
    chk("rst physpage", {12'h0, bus_if.ft2itlb_physpage}, 32'h0);
    bus_if.ft2itlb_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Basic miss timing, cycle by cycle
    bus_if.ft2itlb_valid    = 1'b1;
    bus_if.ft2itlb_virtpage = 20'h00ABC;
    #1; chk("t1 c0 ready", {31'h0, bus_if.ft2itlb_ready}, 32'h0);
    tick(); #1;
    chk("t1 c1 mem_valid", {31'h0, bus_if.itlb2mem_valid}, 32'h1);
    chk("t1 c1 addr", {2'h0, bus_if.itlb2mem_addr}, 32'h0004002);
    tick(); #1;
    chk("t1 c2 mem_valid", {31'h0, bus_if.itlb2mem_valid}, 32'h0);
    tick(); #1;
    chk("t1 c3 mem_valid", {31'h0, bus_if.itlb2mem_valid}, 32'h1);
    chk("t1 c3 addr", {2'h0, bus_if.itlb2mem_addr}, 32'h48D16BC);
    tick(); #1;
    chk("t1 c4 ready", {31'h0, bus_if.ft2itlb_ready}, 32'h0);
    tick(); #1;
    chk("t1 c5 ready", {31'h0, bus_if.ft2itlb_ready}, 32'h1);
    chk("t1 c5 physpage", {12'h0, bus_if.ft2itlb_physpage}, 32'h7F001);
    chk("t1 c5 pagefault", {31'h0, bus_if.ft2itlb_pagefault}, 32'h0);
    tick();
    bus_if.ft2itlb_valid = 1'b0;
    tick();
    walk("t1 rehit", 20'h00ABC, 20'h7F001, 1'b0, 0);

    // Capacity: ENTRIES+1 pages evict the oldest, pointer wraps
    tick(); walk("t2 fill 801", 20'h00801, 20'h50001, 1'b0, 5);
    tick(); walk("t2 fill 802", 20'h00802, 20'h50002, 1'b0, 5);
    tick(); walk("t2 fill 803", 20'h00803, 20'h50003, 1'b0, 5);
    tick(); walk("t2 fill 804", 20'h00804, 20'h50004, 1'b0, 5);
    tick(); walk("t2 hit 801", 20'h00801, 20'h50001, 1'b0, 0);
    tick(); walk("t2 evicted abc", 20'h00ABC, 20'h7F001, 1'b0, 5);
    tick(); walk("t2 hit 802", 20'h00802, 20'h50002, 1'b0, 0);
    tick(); walk("t2 hit 804", 20'h00804, 20'h50004, 1'b0, 0);
    tick(); walk("t2 wrap 801", 20'h00801, 20'h50001, 1'b0, 5);

    // Page faults: L1 fault held, exit on vpage change, never cached; L2 fault
    tick(); walk("t3 pde fault", 20'h01005, 20'h0, 1'b1, 3);
    tick(); #1;
    chk("t3 held ready", {31'h0, bus_if.ft2itlb_ready}, 32'h1);
    chk("t3 held pagefault", {31'h0, bus_if.ft2itlb_pagefault}, 32'h1);
    tick(); walk("t3 exit walk", 20'h00C01, 20'h60001, 1'b0, 6);
    tick(); walk("t3 not cached", 20'h01005, 20'h0, 1'b1, 3);
    tick(); walk("t3 pte fault", 20'h00C07, 20'h0, 1'b1, 6);
    bus_if.ft2itlb_valid = 1'b0;
    tick();

    // Flush in L2_WAIT ahead of the data
    rsp_delay               = 2;
    bus_if.ft2itlb_valid    = 1'b1;
    bus_if.ft2itlb_virtpage = 20'h00C02;
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("t4 l2 req addr", {2'h0, bus_if.itlb2mem_addr}, 32'h8888802);
    tick();
    flush = 1'b1;
    bus_if.ft2itlb_valid = 1'b0;
    tick();
    flush = 1'b0;
    bus_if.ft2itlb_valid    = 1'b1;
    bus_if.ft2itlb_virtpage = 20'h00ABC;
    #1; chk("t4 flushed abc", {31'h0, bus_if.ft2itlb_ready}, 32'h0);
    tick();
    bus_if.ft2itlb_valid = 1'b0;
    tick(); tick(); #1;
    chk("t4 no restart", {31'h0, bus_if.itlb2mem_valid}, 32'h0);
    rsp_delay = 0;
    tick(); walk("t4 rewalk", 20'h00C02, 20'h60002, 1'b0, 5);

    // Flush coincident with the fill
    tick();
    bus_if.ft2itlb_virtpage = 20'h00C03;
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    bus_if.ft2itlb_valid = 1'b0;
    tick();
    flush = 1'b0;
    walk("t4b rewalk", 20'h00C03, 20'h60003, 1'b0, 5);

    // Memory back-pressure and a mid-walk hit
    tick();
    bus_if.mem2itlb_ready   = 1'b0;
    bus_if.ft2itlb_virtpage = 20'h00C04;
    #1; chk("t5 c0 ready", {31'h0, bus_if.ft2itlb_ready}, 32'h0);
    tick(); #1;
    chk("t5 c1 valid", {31'h0, bus_if.itlb2mem_valid}, 32'h1);
    chk("t5 c1 addr", {2'h0, bus_if.itlb2mem_addr}, 32'h0004003);
    tick();
    bus_if.ft2itlb_virtpage = 20'h00C03;
    #1;
    chk("t5 c2 hit ready", {31'h0, bus_if.ft2itlb_ready}, 32'h1);
    chk("t5 c2 hit physpage", {12'h0, bus_if.ft2itlb_physpage}, 32'h60003);
    chk("t5 c2 valid", {31'h0, bus_if.itlb2mem_valid}, 32'h1);
    chk("t5 c2 addr", {2'h0, bus_if.itlb2mem_addr}, 32'h0004003);
    tick(); #1;
    chk("t5 c3 valid", {31'h0, bus_if.itlb2mem_valid}, 32'h1);
    chk("t5 c3 addr", {2'h0, bus_if.itlb2mem_addr}, 32'h0004003);
    bus_if.mem2itlb_ready = 1'b1;
    tick(); tick(); #1;
    chk("t5 l2 addr", {2'h0, bus_if.itlb2mem_addr}, 32'h8888804);
    tick(); tick();
    walk("t5 filled c04", 20'h00C04, 20'h60004, 1'b0, 0);

    // Reset during L1_WAIT
    tick();
    rsp_delay               = 2;
    bus_if.ft2itlb_virtpage = 20'h00C05;
    tick(); tick();
    rst_n = 1'b0;
    bus_if.ft2itlb_virtpage = 20'h00C04;
    #1;
    chk("t6 rst mem_valid", {31'h0, bus_if.itlb2mem_valid}, 32'h0);
    chk("t6 rst c04 miss", {31'h0, bus_if.ft2itlb_ready}, 32'h0);
    bus_if.ft2itlb_valid = 1'b0;
    rsp_delay = 0;
    tick();
    rst_n = 1'b1;
    tick();
    walk("t6 c04 rewalk", 20'h00C04, 20'h60004, 1'b0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
